// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master and its edge generator.
// The state encoding and mode constants are shared with the bench slave model.
package spi_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLead,
        StXfer,
        StTrail
    } spi_state_e;

    // Mode encoding is {cpol, cpha}.
    localparam logic [1:0] Mode0 = 2'b00;
    localparam logic [1:0] Mode1 = 2'b01;
    localparam logic [1:0] Mode2 = 2'b10;
    localparam logic [1:0] Mode3 = 2'b11;

    localparam int unsigned DefClkDiv = 4;
    localparam int unsigned DefDataW  = 8;

    // Edge counter must hold 2*DATA_W data edges plus the trailing half-period strobe.
    function automatic int unsigned edge_cnt_w(input int unsigned data_w);
        return $clog2(2 * data_w + 2);
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period divider and edge counter for the SPI master.
// edge_idx_o is the 1-based number of the edge that fires with edge_stb_o.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = DefClkDiv,
    parameter int unsigned EDGE_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              run_i,
    input  logic              clr_i,
    output logic              edge_stb_o,
    output logic [EDGE_W-1:0] edge_idx_o
);

    localparam int unsigned     DivW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

    logic [DivW-1:0]   div_q;
    logic [EDGE_W-1:0] cnt_q;

    assign edge_stb_o = run_i && (div_q == DivMax);
    assign edge_idx_o = cnt_q + EDGE_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q <= '0;
            cnt_q <= '0;
        end else if (clr_i || !run_i) begin
            div_q <= '0;
            cnt_q <= '0;
        end else if (edge_stb_o) begin
            div_q <= '0;
            cnt_q <= cnt_q + EDGE_W'(1);
        end else begin
            div_q <= div_q + DivW'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI master: one DATA_W-bit word per accepted transmit word, all four CPOL/CPHA
// modes, and back-to-back bursts with ena held high. CLK_DIV must be at least 2.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = DefClkDiv,
    parameter int unsigned DATA_W  = DefDataW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              busy_o,
    output logic              sck_o,
    output logic              mosi_o,
    input  logic              miso_i,
    output logic              ena_o
);

    localparam int unsigned       EdgeW    = edge_cnt_w(DATA_W);
    localparam logic [EdgeW-1:0]  LastEdge = EdgeW'(2 * DATA_W);
    localparam logic [EdgeW-1:0]  FirstEdge = EdgeW'(1);

    spi_state_e        state_q;
    logic              sck_q;
    logic              mosi_q;
    logic              ena_q;
    logic              busy_q;
    logic              rx_valid_q;
    logic [DATA_W-1:0] rx_data_q;
    logic [DATA_W-1:0] tx_sh_q;
    logic [DATA_W-1:0] rx_sh_q;
    logic              cpol_q;
    logic              cpha_q;
    logic              samp_q;
    logic              last_q;

    logic              edge_stb;
    logic [EdgeW-1:0]  edge_idx;
    logic              run;
    logic              last_edge;
    logic              accept;
    logic              data_edge;
    logic              shift_edge;
    logic [DATA_W-1:0] rx_shift;

    assign run        = (state_q != StIdle);
    assign last_edge  = edge_stb && (state_q == StXfer) && (edge_idx == LastEdge);
    assign tx_ready_o = !rst_i && ((state_q == StIdle) || last_edge);
    assign accept     = tx_valid_i && tx_ready_o;
    assign data_edge  = edge_stb && ((state_q == StLead) || (state_q == StXfer));

    // cpha=0 shifts on even edges, cpha=1 on odd edges from 3; the MSB needs no shift.
    assign shift_edge = cpha_q ? (edge_idx[0] && (edge_idx != FirstEdge))
                               : (!edge_idx[0] && (edge_idx != LastEdge));

    assign rx_shift = {rx_sh_q[DATA_W-2:0], miso_i};

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV),
        .EDGE_W  (EdgeW)
    ) u_clk_gen (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .run_i      (run),
        .clr_i      (accept),
        .edge_stb_o (edge_stb),
        .edge_idx_o (edge_idx)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            ena_q      <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            samp_q     <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            // miso is captured the cycle after the strobe, once sck has visibly moved.
            samp_q     <= data_edge && (edge_idx[0] != cpha_q);
            last_q     <= last_edge;
            rx_valid_q <= last_q;

            if (samp_q) begin
                rx_sh_q <= rx_shift;
            end
            if (last_q) begin
                rx_data_q <= samp_q ? rx_shift : rx_sh_q;
            end

            unique case (state_q)
                StIdle: begin
                    sck_q <= cpol_i;
                    if (accept) begin
                        state_q <= StLead;
                        ena_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        tx_sh_q <= tx_data_i;
                        mosi_q  <= tx_data_i[DATA_W-1];
                        cpol_q  <= cpol_i;
                        cpha_q  <= cpha_i;
                    end
                end
                StLead: begin
                    if (edge_stb) begin
                        sck_q   <= ~sck_q;
                        state_q <= StXfer;
                    end
                end
                StXfer: begin
                    if (edge_stb) begin
                        sck_q <= ~sck_q;
                        if (edge_idx == LastEdge) begin
                            if (tx_valid_i) begin
                                tx_sh_q <= tx_data_i;
                                // cpha=1 still samples on this edge; its MSB goes out on edge 1.
                                if (!cpha_q) begin
                                    mosi_q <= tx_data_i[DATA_W-1];
                                end
                            end else begin
                                state_q <= StTrail;
                            end
                        end else if (shift_edge) begin
                            mosi_q  <= tx_sh_q[DATA_W-2];
                            tx_sh_q <= tx_sh_q << 1;
                        end else if (cpha_q && (edge_idx == FirstEdge)) begin
                            mosi_q <= tx_sh_q[DATA_W-1];
                        end
                    end
                end
                StTrail: begin
                    if (edge_stb) begin
                        state_q <= StIdle;
                        ena_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign sck_o      = sck_q;
    assign mosi_o     = mosi_q;
    assign ena_o      = ena_q;
    assign busy_o     = busy_q;
    assign rx_valid_o = rx_valid_q;
    assign rx_data_o  = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a clk-synchronous slave memory model on the CLK_DIV=4
// instance and a mosi->miso loopback on a CLK_DIV=2 instance.
module tb_spi_master;
    import spi_pkg::*;

    logic       clk;
    logic       rst;
    logic       cpol, cpha;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy, sck, mosi, miso, ena;

    logic       cpol2, cpha2;
    logic [7:0] tx2_data;
    logic       tx2_valid, tx2_ready;
    logic [7:0] rx2_data;
    logic       rx2_valid, busy2, sck2, mosi2, ena2;

    int errors = 0;
    int checks = 0;

    spi_master #(.CLK_DIV(4), .DATA_W(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cpol_i     (cpol),
        .cpha_i     (cpha),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .busy_o     (busy),
        .sck_o      (sck),
        .mosi_o     (mosi),
        .miso_i     (miso),
        .ena_o      (ena)
    );

    spi_master #(.CLK_DIV(2), .DATA_W(8)) dut2 (
        .clk_i      (clk),
        .rst_i      (rst),
        .cpol_i     (cpol2),
        .cpha_i     (cpha2),
        .tx_data_i  (tx2_data),
        .tx_valid_i (tx2_valid),
        .tx_ready_o (tx2_ready),
        .rx_data_o  (rx2_data),
        .rx_valid_o (rx2_valid),
        .busy_o     (busy2),
        .sck_o      (sck2),
        .mosi_o     (mosi2),
        .miso_i     (mosi2),
        .ena_o      (ena2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave memory model: responds with 1,2,3,... and stores every received byte.
    logic       slv_clr;
    logic       sck_prev, ena_prev;
    logic [7:0] sl_out, sl_in;
    logic [3:0] ridx, widx;
    logic [2:0] scnt;
    logic [7:0] stored [0:15];
    logic [7:0] sl_in_next, resp;
    logic       sl_sample;

    assign miso       = sl_out[7];
    assign sl_in_next = {sl_in[6:0], mosi};
    assign resp       = {4'h0, ridx} + 8'd1;
    assign sl_sample  = (sck_prev == cpol) ^ cpha;

    always @(posedge clk) begin
        sck_prev <= sck;
        ena_prev <= ena;
        if (slv_clr) begin
            ridx      <= 4'd0;
            widx      <= 4'd0;
            scnt      <= 3'd0;
            sl_out    <= 8'h00;
            stored[0] <= 8'h00;
        end else if (!ena) begin
            scnt <= 3'd0;
        end else if (!ena_prev) begin
            sl_out <= resp;
            ridx   <= ridx + 4'd1;
            scnt   <= 3'd0;
        end else if (sck != sck_prev) begin
            if (sl_sample) begin
                sl_in <= sl_in_next;
                if (scnt == 3'd7) begin
                    stored[widx] <= sl_in_next;
                    widx         <= widx + 4'd1;
                    scnt         <= 3'd0;
                    if (cpha) begin
                        sl_out <= resp;
                        ridx   <= ridx + 4'd1;
                    end
                end else begin
                    scnt <= scnt + 3'd1;
                end
            end else if (scnt == 3'd0) begin
                if (!cpha) begin
                    sl_out <= resp;
                    ridx   <= ridx + 4'd1;
                end
            end else begin
                sl_out <= sl_out << 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic slave_reset();
        slv_clr = 1'b1;
        step();
        slv_clr = 1'b0;
        step();
        step();
    endtask

    // One non-burst transfer; k counts cycles after the accept cycle.
    task automatic run_xfer(input logic [7:0] d, output logic [7:0] rx, output int rx_k,
                            output int ena_k, output int tog, output int end_k);
        int   w;
        int   k;
        logic prev;
        rx = 8'h00; rx_k = -1; ena_k = 0; tog = 0; w = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && w < 200) begin
            step();
            w++;
        end
        chk("accept_wait", 32'(tx_ready), 32'd1);
        prev = sck;
        step();
        tx_valid = 1'b0;
        k = 1;
        while (ena && k < 600) begin
            if (sck !== prev) tog++;
            prev = sck;
            if (rx_valid) begin
                rx   = rx_data;
                rx_k = k;
            end
            ena_k++;
            step();
            k++;
        end
        end_k = k;
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [7:0] tx;
        logic [7:0] exp_rx;
        int         exp_rx_k;
        int         exp_ena;
        int         exp_end;
    } vec_t;

    vec_t       vecs [4];
    logic [7:0] rx;
    int         rx_k, ena_k, tog, end_k;
    logic [7:0] bdat [4];
    logic [7:0] rxs [8];
    int         nrx;

    initial begin
        vecs[0] = '{Mode0, 8'hA5, 8'h01, 66, 68, 69};
        vecs[1] = '{Mode1, 8'h3C, 8'h01, 66, 68, 69};
        vecs[2] = '{Mode2, 8'h3C, 8'h01, 66, 68, 69};
        vecs[3] = '{Mode3, 8'h3C, 8'h01, 66, 68, 69};
        bdat[0] = 8'h10; bdat[1] = 8'h20; bdat[2] = 8'h30; bdat[3] = 8'h40;

        rst = 1'b1; cpol = 1'b0; cpha = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
        cpol2 = 1'b0; cpha2 = 1'b0; tx2_data = 8'h00; tx2_valid = 1'b0; slv_clr = 1'b0;
        step(); step(); step();

        // Reset state
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        chk("rst_sck", 32'(sck), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_ena", 32'(ena), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();

        // Single transfers in all four modes
        for (int i = 0; i < 4; i++) begin
            cpol = vecs[i].mode[1];
            cpha = vecs[i].mode[0];
            slave_reset();
            chk($sformatf("v%0d_idle_sck", i), 32'(sck), 32'(vecs[i].mode[1]));
            run_xfer(vecs[i].tx, rx, rx_k, ena_k, tog, end_k);
            chk($sformatf("v%0d_rx_data", i), 32'(rx), 32'(vecs[i].exp_rx));
            chk($sformatf("v%0d_rx_k", i), 32'(rx_k), 32'(vecs[i].exp_rx_k));
            chk($sformatf("v%0d_ena_cycles", i), 32'(ena_k), 32'(vecs[i].exp_ena));
            chk($sformatf("v%0d_sck_toggles", i), 32'(tog), 32'd16);
            chk($sformatf("v%0d_end_k", i), 32'(end_k), 32'(vecs[i].exp_end));
            chk($sformatf("v%0d_ready_end", i), 32'(tx_ready), 32'd1);
            chk($sformatf("v%0d_end_sck", i), 32'(sck), 32'(vecs[i].mode[1]));
            chk($sformatf("v%0d_slave_byte", i), 32'(stored[0]), 32'(vecs[i].tx));
        end

        // Four-byte burst with tx_valid held, mode 0
        begin
            int   k, idx, rises, gaps, last_tog, w;
            logic prev, acc_now;
            cpol = 1'b0; cpha = 1'b0;
            slave_reset();
            nrx = 0; rises = 0; gaps = 0; last_tog = 0; ena_k = 0; idx = 0; w = 0;
            tx_data = bdat[0]; tx_valid = 1'b1;
            while (!tx_ready && w < 200) begin step(); w++; end
            prev = sck;
            step();
            idx = 1; tx_data = bdat[1];
            k = 1;
            while (ena && k < 1000) begin
                acc_now = tx_valid && tx_ready;
                if (sck && !prev) rises++;
                if (sck !== prev) begin
                    if (last_tog > 0 && (k - last_tog) != 4) gaps++;
                    last_tog = k;
                end
                prev = sck;
                if (rx_valid && nrx < 8) begin rxs[nrx] = rx_data; nrx++; end
                ena_k++;
                step();
                k++;
                if (acc_now) begin
                    idx++;
                    if (idx < 4) tx_data = bdat[idx];
                    else tx_valid = 1'b0;
                end
            end
            chk("burst_rises", 32'(rises), 32'd32);
            chk("burst_gaps", 32'(gaps), 32'd0);
            chk("burst_ena_cycles", 32'(ena_k), 32'd260);
            chk("burst_nrx", 32'(nrx), 32'd4);
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("burst_rx%0d", j), 32'(rxs[j]), 32'(j + 1));
                chk($sformatf("burst_slave%0d", j), 32'(stored[j]), 32'(bdat[j]));
            end
        end

        // tx_valid raised mid-byte is held off until the final-edge cycle
        begin
            int   k, first_ready, early, w;
            logic acc_now;
            slave_reset();
            nrx = 0; first_ready = -1; early = 0; w = 0;
            tx_data = 8'h81; tx_valid = 1'b1;
            while (!tx_ready && w < 200) begin step(); w++; end
            step();
            tx_valid = 1'b0;
            k = 1;
            while (ena && k < 600) begin
                if (k == 20) begin tx_data = 8'h77; tx_valid = 1'b1; end
                if (k >= 2 && k < 64 && tx_ready) early++;
                acc_now = tx_valid && tx_ready;
                if (acc_now && first_ready < 0) first_ready = k;
                if (rx_valid && nrx < 8) begin rxs[nrx] = rx_data; nrx++; end
                step();
                k++;
                if (acc_now) tx_valid = 1'b0;
            end
            chk("mid_early_ready", 32'(early), 32'd0);
            chk("mid_accept_k", 32'(first_ready), 32'd64);
            chk("mid_end_k", 32'(k), 32'd133);
            chk("mid_rx1", 32'(rxs[1]), 32'h02);
            chk("mid_slave1", 32'(stored[1]), 32'h77);
        end

        // Reset pulsed just after edge 7
        begin
            int k, w, rxv;
            slave_reset();
            w = 0;
            tx_data = 8'hF0; tx_valid = 1'b1;
            while (!tx_ready && w < 200) begin step(); w++; end
            step();
            tx_valid = 1'b0;
            for (k = 1; k < 29; k++) step();
            chk("rst7_sck_before", 32'(sck), 32'd1);
            rst = 1'b1;
            chk("rst7_ready_in_rst", 32'(tx_ready), 32'd0);
            step();
            rst = 1'b0;
            chk("rst7_ena", 32'(ena), 32'd0);
            chk("rst7_sck", 32'(sck), 32'd0);
            chk("rst7_mosi", 32'(mosi), 32'd0);
            chk("rst7_busy", 32'(busy), 32'd0);
            rxv = 0;
            for (int j = 0; j < 100; j++) begin
                if (rx_valid) rxv++;
                step();
            end
            chk("rst7_no_rx_valid", 32'(rxv), 32'd0);
            slave_reset();
            run_xfer(8'h5A, rx, rx_k, ena_k, tog, end_k);
            chk("post_rst_rx", 32'(rx), 32'h01);
            chk("post_rst_rx_k", 32'(rx_k), 32'd66);
            chk("post_rst_slave", 32'(stored[0]), 32'h5A);
        end

        // CLK_DIV=2: cpol tracking in IDLE, cpol change mid-byte ignored
        begin
            int   k, rk, t2;
            logic prev;
            logic [7:0] r2;
            step();
            chk("div2_sck_idle0", 32'(sck2), 32'd0);
            cpol2 = 1'b1;
            chk("div2_sck_not_yet", 32'(sck2), 32'd0);
            step();
            chk("div2_sck_follow", 32'(sck2), 32'd1);
            tx2_data = 8'hC3; tx2_valid = 1'b1;
            chk("div2_ready_idle", 32'(tx2_ready), 32'd1);
            prev = sck2;
            step();
            tx2_valid = 1'b0;
            k = 1; rk = -1; t2 = 0; r2 = 8'h00;
            while (ena2 && k < 200) begin
                if (k == 10) cpol2 = 1'b0;
                if (sck2 !== prev) t2++;
                prev = sck2;
                if (rx2_valid) begin r2 = rx2_data; rk = k; end
                step();
                k++;
            end
            chk("div2_rx", 32'(r2), 32'hC3);
            chk("div2_rx_k", 32'(rk), 32'd34);
            chk("div2_toggles", 32'(t2), 32'd16);
            chk("div2_end_k", 32'(k), 32'd35);
            chk("div2_end_sck", 32'(sck2), 32'd1);
            step();
            chk("div2_sck_track", 32'(sck2), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_master.md
# spi_master

Synthesizable SPI master that drives `sck`, `mosi` and an active-high slave enable `ena`. It shifts out one byte per accepted transmit word and returns the byte captured on `miso`. It supports all four CPOL/CPHA modes and back-to-back bursts with `ena` held high between bytes. It is the initiator end of the chip's SPI link and is exercised against the bench SPI slave memory model.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per `sck` half-period; must be ≥ 2.
- `DATA_W`, default 8: bits per transfer, MSB first.
- `clk` in, 1: system clock; all logic is on the rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `cpol` in, 1: idle level of `sck`; sampled when a burst's first byte is accepted.
- `cpha` in, 1: 0 = sample on leading edge, 1 = sample on trailing edge; sampled with `cpol`.
- `tx_data` in, DATA_W: byte to transmit.
- `tx_valid` in, 1: `tx_data` is valid.
- `tx_ready` out, 1: the block can accept a byte; transfer happens when `tx_valid` && `tx_ready`.
- `rx_data` out, DATA_W: last received byte; holds its value until the next `rx_valid`.
- `rx_valid` out, 1: one-cycle pulse when `rx_data` updates.
- `busy` out, 1: high whenever `state` ≠ IDLE.
- `sck` out, 1: serial clock.
- `mosi` out, 1: serial data out.
- `miso` in, 1: serial data in; the bench guarantees it is synchronous to `clk`.
- `ena` out, 1: slave enable, active high.

## Operation
- States:
  - IDLE → LEAD on accept.
  - LEAD lasts one half-period, then → XFER.
  - XFER covers 2·DATA_W edges. At the last edge: if `tx_valid`, accept the next byte and stay in XFER; otherwise → TRAIL.
  - TRAIL lasts one half-period, then → IDLE.
- `tx_ready` is 1 in IDLE, and in XFER only during the cycle of the final edge. It is 0 in all other cycles and while `rst` is high.
- Accept actions: load the shift register with `tx_data`, latch `cpol`/`cpha` (IDLE accept only), and reset the edge count.
- Edges are numbered 1..2·DATA_W. Each edge toggles `sck`.
- cpha = 0:
  - `mosi` = bit DATA_W-1 from LEAD entry.
  - Sample `miso` on odd edges.
  - Shift `mosi` on even edges 2..2·DATA_W-2.
- cpha = 1:
  - `mosi` = bit DATA_W-1 from LEAD entry.
  - Shift `mosi` on odd edges 3..2·DATA_W-1.
  - Sample `miso` on even edges.
- Burst with cpha = 0: the new byte's MSB appears on `mosi` at edge 2·DATA_W.
- Received bits shift into `rx_data` MSB first.
- In IDLE, `sck` follows the `cpol` input (registered). `mosi` holds its last value. `ena` = 0.
- `cpol`/`cpha` changes during a burst are ignored.

## Timing
- Reset values: `sck`=0, `mosi`=0, `ena`=0, `rx_valid`=0, `rx_data`=0, `busy`=0. State = IDLE and the divider count = 0.
- A reset asserted mid-transfer aborts the transfer. Outputs take their reset values on the next edge and no `rx_valid` is generated.
- Divider: count 0..CLK_DIV-1. An edge strobe fires when count = CLK_DIV-1. Count is cleared on accept.
- Accept at cycle t:
  - `ena`=1 and `busy`=1 at t+1.
  - First `sck` edge at t+1+CLK_DIV.
  - Edge k at t+1+k·CLK_DIV.
- Last edge at t+1+2·DATA_W·CLK_DIV:
  - `rx_valid`=1 and `rx_data` valid in the following cycle.
  - With no burst, `ena` falls CLK_DIV cycles after the last edge, and `tx_ready`=1 in that same cycle.
- Burst: no extra half-period between bytes, and `ena` stays 1.
- `rx_valid` for byte n and the accept of byte n+1 may coincide.
- `sck` never glitches: it changes only on edge strobes or IDLE cpol tracking.

## Structure
- Package `spi_pkg` holds:
  - State enum: IDLE, LEAD, XFER, TRAIL.
  - Mode constants: MODE0..MODE3 = {cpol,cpha}.
  - Default `CLK_DIV`/`DATA_W` localparams.
- One sub-module, `spi_clk_gen`. Ports: `clk`, `rst`, `run`, `clr`, outputs `edge_stb` and `edge_idx`. It owns the divider and the edge counter.
- The top level holds the FSM, shift registers, `sck` toggle flop and output registers.

## Test plan
- Mode 0, CLK_DIV=4; slave model preloaded 0x01,0x02…; send 0xA5 → slave stores 0xA5; `rx_data`=0x01; `rx_valid` at t+66; `ena` high for 68 cycles.
- Modes 1, 2, 3, each sending 0x3C → slave stores 0x3C and `rx_data`=0x01. Check that `sck` idles at `cpol` and that sample edges are leading (cpha=0) or trailing (cpha=1).
- Burst of 4 bytes 0x10,0x20,0x30,0x40 with `tx_valid` held → `ena` stays high throughout, 32 `sck` edges with no gap, `rx_data` = 0x01,0x02,0x03,0x04.
- `tx_valid` asserted while busy mid-byte → `tx_ready`=0 and the byte is not taken until the final-edge cycle.
- `rst` pulsed at edge 7 → next cycle `ena`=0, `sck`=0, no `rx_valid`. A following transfer of 0x5A completes normally.
- CLK_DIV=2 with `cpol` toggled in IDLE → `sck` follows one cycle later. A `cpol` change mid-byte has no effect on the transfer.
